sha256_block_engine: RTL and testbench

- Sequential, parametrised SHA-256 compression engine.
- Accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains multi-block messages, e.g. an 80-byte block header padded to two blocks.
- Computes ROUNDS_PER_CYCLE rounds per clock using an on-the-fly 16-word message schedule.
- Presents the 256-bit digest on an output handshake.
- Replaces the combinational, unclocked hashing path. Round constants and IV come from a shared package, not from ports.

---
 rtl/sha256_pkg.sv | 57 +++++
 rtl/sha256_block_engine_if.sv | 29 ++
 rtl/sha256_round.sv | 18 +
 rtl/sha256_block_engine.sv | 122 ++++++++++++
 tb/tb_sha256_block_engine.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, word types, FSM encodings and bitwise helper functions.
package sha256_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [0:7][WORD_W-1:0]  hash_t;   // element 0 = H0 / a, at the MSBs
    typedef logic [0:15][WORD_W-1:0] sched_t;  // element 0 = window head W_t

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ROUND = 2'd1;
    localparam state_t ST_FINAL = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    localparam hash_t IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [0:63][WORD_W-1:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_block_engine_if.sv
// Block-in / digest-out bus of the SHA-256 engine, plus a state debug tap.
interface sha256_block_engine_if;
    import sha256_pkg::*;

    // Both handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds its payload stable while valid is high and ready low.
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_first;
    logic         in_last;
    logic [255:0] iv_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest;
    logic         busy;
    state_t       dbg_state;

    modport master (
        output in_valid, in_block, in_first, in_last, iv_in, out_ready,
        input  in_ready, out_valid, digest, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_block, in_first, in_last, iv_in, out_ready,
        output in_ready, out_valid, digest, busy, dbg_state
    );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, W_t, K_t) -> (a'..h').
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t i_v,
    input  word_t i_w,
    input  word_t i_k,
    output hash_t o_v
);

    word_t w_t1;
    word_t w_t2;

    assign w_t1 = i_v[7] + bsig1(i_v[4]) + ch(i_v[4], i_v[5], i_v[6]) + i_k + i_w;
    assign w_t2 = bsig0(i_v[0]) + maj(i_v[0], i_v[1], i_v[2]);
    assign o_v  = {w_t1 + w_t2, i_v[0], i_v[1], i_v[2], i_v[3] + w_t1, i_v[4], i_v[5], i_v[6]};

endmodule

// File: rtl/sha256_block_engine.sv
// Sequential SHA-256 block engine: ROUNDS_PER_CYCLE rounds per clock over a sliding
// 16-word schedule window, with chaining across blocks and a held digest output.
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit EXT_IV           = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    sha256_block_engine_if.slave bus
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
        $error("sha256_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t     r_state;
    logic [6:0] r_cnt;
    logic       r_last;
    hash_t      r_h;
    hash_t      r_v;
    hash_t      r_digest;
    sched_t     r_w;

    hash_t      w_h_start;
    hash_t      w_h_sum;
    hash_t      w_round_out;
    sched_t     w_w_next;
    word_t      w_ext [16+R];
    logic [6:0] w_cnt_next;

    // A non-first block continues from whatever chaining value the last block left.
    assign w_h_start  = bus.in_first ? (EXT_IV ? hash_t'(bus.iv_in) : IV) : r_h;
    assign w_cnt_next = r_cnt + 7'(R);

    // Extend the window by R words; later new words may depend on earlier new ones.
    always_comb begin
        for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
        for (int j = 0; j < R; j++) begin
            w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
        end
        for (int i = 0; i < 16; i++) w_w_next[i] = w_ext[i+R];
        for (int i = 0; i < 8; i++) w_h_sum[i] = r_h[i] + r_v[i];
    end

    for (genvar j = 0; j < R; j++) begin : g_round
        hash_t      w_in;
        hash_t      w_out;
        logic [5:0] w_kidx;

        if (j == 0) begin : g_head
            assign w_in = r_v;
        end else begin : g_link
            assign w_in = g_round[j-1].w_out;
        end

        assign w_kidx = r_cnt[5:0] + 6'(j);

        sha256_round u_round (
            .i_v (w_in),
            .i_w (r_w[j]),
            .i_k (K[w_kidx]),
            .o_v (w_out)
        );
    end

    assign w_round_out = g_round[R-1].w_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_h      <= IV;
            r_v      <= '0;
            r_w      <= '0;
            r_digest <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_w     <= bus.in_block;
                        r_cnt   <= '0;
                        r_last  <= bus.in_last;
                        r_h     <= w_h_start;
                        r_v     <= w_h_start;
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_v   <= w_round_out;
                    r_w   <= w_w_next;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == 7'd64) r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_h <= w_h_sum;
                    if (r_last) begin
                        r_digest <= w_h_sum;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.digest    = r_digest;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sha256_block_engine.sv
// Bench for sha256_block_engine: five builds (R=1,2,4,8 and EXT_IV) against known
// answers and a plain-array SHA-256 compression model.
module tb_sha256_block_engine;

    localparam int N = 5;
    localparam int RPC_OF [N] = '{1, 2, 4, 8, 1};
    localparam int EXT_K = 4;

    localparam logic [255:0] TB_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_ABC = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_2A  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_2B  = {448'h0, 64'h1c0};
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_2   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT arrays ----------------
    logic         d_in_valid  [N];
    logic [511:0] d_in_block  [N];
    logic         d_in_first  [N];
    logic         d_in_last   [N];
    logic [255:0] d_iv_in     [N];
    logic         d_out_ready [N];
    logic         q_in_ready  [N];
    logic         q_out_valid [N];
    logic [255:0] q_digest    [N];
    logic         q_busy      [N];

    for (genvar k = 0; k < N; k++) begin : g_dut
        sha256_block_engine_if bus ();

        assign bus.in_valid    = d_in_valid[k];
        assign bus.in_block    = d_in_block[k];
        assign bus.in_first    = d_in_first[k];
        assign bus.in_last     = d_in_last[k];
        assign bus.iv_in       = d_iv_in[k];
        assign bus.out_ready   = d_out_ready[k];
        assign q_in_ready[k]   = bus.in_ready;
        assign q_out_valid[k]  = bus.out_valid;
        assign q_digest[k]     = bus.digest;
        assign q_busy[k]       = bus.busy;

        sha256_block_engine #(
            .ROUNDS_PER_CYCLE (RPC_OF[k]),
            .EXT_IV           (k == EXT_K)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [255:0] model_h [N];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] hv [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 8; i++) hv[i] = h_in[255-32*i -: 32];
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + TK[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic do_block(input int k, input logic [511:0] blk, input bit first, input bit last,
                            input logic [255:0] iv, input bit spam, input int hold);
        int           n;
        int           lat;
        bit           saw;
        logic [255:0] ref_h;
        ref_h      = ref_compress(first ? ((k == EXT_K) ? iv : TB_IV) : model_h[k], blk);
        model_h[k] = ref_h;

        @(negedge clk);
        d_in_block[k] = blk;
        d_in_first[k] = first;
        d_in_last[k]  = last;
        d_iv_in[k]    = iv;
        d_in_valid[k] = 1'b1;
        n = 0;
        while (q_in_ready[k] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", q_in_ready[k], 1'b1);

        // Accept happens on the coming edge; optionally keep offering junk while busy.
        @(negedge clk);
        d_in_valid[k] = spam;
        d_in_block[k] = rand512();
        d_in_first[k] = 1'($urandom_range(0, 1));
        d_in_last[k]  = 1'($urandom_range(0, 1));
        d_iv_in[k]    = rand256();
        check("busy_in_round", q_busy[k], 1'b1);
        lat = 1;
        saw = 1'b0;
        while (lat < 300) begin
            if (q_out_valid[k] === 1'b1) saw = 1'b1;
            if (last ? (q_out_valid[k] === 1'b1) : (q_in_ready[k] === 1'b1)) break;
            @(negedge clk);
            lat++;
        end
        d_in_valid[k] = 1'b0;
        check(last ? "latency_out_valid" : "latency_next_accept", 256'(lat), 256'(64 / RPC_OF[k] + 2));

        if (!last) begin
            check("no_out_valid_mid_chain", saw, 1'b0);
        end else begin
            check("digest_vs_model", q_digest[k], ref_h);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_digest", q_digest[k], ref_h);
                check("hold_in_ready", q_in_ready[k], 1'b0);
                check("hold_out_valid", q_out_valid[k], 1'b1);
            end
            d_out_ready[k] = 1'b1;
            @(negedge clk);
            d_out_ready[k] = 1'b0;
            check("release_out_valid", q_out_valid[k], 1'b0);
            check("release_in_ready", q_in_ready[k], 1'b1);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed / random sequence ----------------
    initial begin
        for (int k = 0; k < N; k++) begin
            d_in_valid[k]  = 1'b0;
            d_in_block[k]  = '0;
            d_in_first[k]  = 1'b0;
            d_in_last[k]   = 1'b0;
            d_iv_in[k]     = '0;
            d_out_ready[k] = 1'b0;
            model_h[k]     = TB_IV;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < N; k++) begin
            check("reset_in_ready", q_in_ready[k], 1'b1);
            check("reset_out_valid", q_out_valid[k], 1'b0);
            check("reset_busy", q_busy[k], 1'b0);
            check("reset_digest", q_digest[k], '0);
        end

        // "abc" on R=1 with 20 cycles of backpressure.
        do_block(0, BLK_ABC, 1'b1, 1'b1, '0, 1'b0, 20);
        check("abc_r1_kat", q_digest[0], DIG_ABC);

        // Two-block message, second block chains.
        do_block(0, BLK_2A, 1'b1, 1'b0, '0, 1'b0, 0);
        do_block(0, BLK_2B, 1'b0, 1'b1, '0, 1'b1, 0);
        check("two_block_kat", q_digest[0], DIG_2);

        // Unrolled builds.
        for (int k = 1; k < 4; k++) begin
            do_block(k, BLK_ABC, 1'b1, 1'b1, '0, 1'b1, 2);
            check("abc_unrolled_kat", q_digest[k], DIG_ABC);
        end

        // out_ready with nothing to deliver.
        d_out_ready[3] = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_out_valid", q_out_valid[3], 1'b0);
        check("idle_ready_in_ready", q_in_ready[3], 1'b1);
        d_out_ready[3] = 1'b0;

        // Restart mid-chain with in_first.
        do_block(2, rand512(), 1'b1, 1'b0, '0, 1'b0, 0);
        do_block(2, BLK_ABC, 1'b1, 1'b1, '0, 1'b0, 0);
        check("restart_mid_chain_kat", q_digest[2], DIG_ABC);

        // Asynchronous reset around round 30.
        @(negedge clk);
        d_in_block[0] = BLK_ABC;
        d_in_first[0] = 1'b1;
        d_in_last[0]  = 1'b1;
        d_in_valid[0] = 1'b1;
        @(negedge clk);
        d_in_valid[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_reset_busy", q_busy[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", q_out_valid[0], 1'b0);
        check("async_reset_in_ready", q_in_ready[0], 1'b1);
        check("async_reset_busy", q_busy[0], 1'b0);
        check("async_reset_digest", q_digest[0], '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) model_h[k] = TB_IV;

        do_block(0, BLK_ABC, 1'b1, 1'b1, '0, 1'b0, 0);
        check("abc_after_reset_kat", q_digest[0], DIG_ABC);
        do_block(1, BLK_ABC, 1'b0, 1'b1, '0, 1'b0, 0);
        check("first0_from_reset_iv_kat", q_digest[1], DIG_ABC);

        // External IV build.
        do_block(EXT_K, '0, 1'b1, 1'b1, '0, 1'b0, 0);
        do_block(EXT_K, BLK_ABC, 1'b1, 1'b1, TB_IV, 1'b0, 0);
        check("ext_iv_abc_kat", q_digest[EXT_K], DIG_ABC);
        do_block(EXT_K, rand512(), 1'b1, 1'b0, rand256(), 1'b0, 0);
        do_block(EXT_K, rand512(), 1'b0, 1'b1, rand256(), 1'b0, 0);

        // Random chains across all builds.
        for (int it = 0; it < 14; it++) begin
            do_block($urandom_range(0, N - 1), rand512(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rand256(), 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
